// File: rtl/axi_stream_pkg.sv
// Shared sizing and types for the AXI-Stream byte-qualified packer.
package axi_stream_pkg;
  localparam int unsigned T_DATA_W  = 4;
  localparam int unsigned DATA_BITS = 8 * T_DATA_W;
  localparam int unsigned QDEPTH    = 2;
  localparam int unsigned PTR_W     = 1;

  typedef logic [PTR_W-1:0]             qptr_t;
  typedef logic [$clog2(QDEPTH+1)-1:0]  qcnt_t;

  // What the output register does on the coming edge.
  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_BYPASS,
    ACT_DRAIN,
    ACT_STALL
  } out_act_e;
endpackage

// File: rtl/axi_byte_mask.sv
// Zeroes every byte of a word whose keep bit is clear.
module axi_byte_mask
  import axi_stream_pkg::*;
#(
  parameter int unsigned t_data_w = T_DATA_W
) (
  input  logic [8*t_data_w-1:0] data,
  input  logic [t_data_w-1:0]   keep,
  output logic [8*t_data_w-1:0] masked
);

  for (genvar i = 0; i < t_data_w; i++) begin : g_byte
    assign masked[8*i +: 8] = keep[i] ? data[8*i +: 8] : 8'h00;
  end

endmodule

// File: rtl/axi_stream_f.sv
// Byte-qualified packer feeding a write FIFO, with a 2-entry queue to ride out full stalls.
module axi_stream_f
  import axi_stream_pkg::*;
#(
  parameter int unsigned t_data_w = T_DATA_W
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [t_data_w-1:0]   info_bits,
  input  logic [8*t_data_w-1:0] dsp_in_data,
  input  logic                  full,
  output logic [8*t_data_w-1:0] data_word,
  output logic                  w_en
);

  localparam int unsigned DW = 8 * t_data_w;
  localparam qcnt_t Q_FULL = qcnt_t'(QDEPTH);

  logic [DW-1:0] masked;
  logic          beat_valid;
  logic [DW-1:0] q_mem [QDEPTH];
  qptr_t         rd_ptr;
  qptr_t         wr_ptr;
  qcnt_t         count;
  out_act_e      act;
  logic          push;
  logic          pop;

  axi_byte_mask #(
    .t_data_w (t_data_w)
  ) u_mask (
    .data   (dsp_in_data),
    .keep   (info_bits),
    .masked (masked)
  );

  assign beat_valid = |info_bits;

  // An empty queue lets a beat bypass straight to the output register.
  always_comb begin
    act  = ACT_IDLE;
    push = 1'b0;
    pop  = 1'b0;
    if (full) begin
      act  = ACT_STALL;
      push = beat_valid && (count < Q_FULL);
    end else if (count != '0) begin
      act  = ACT_DRAIN;
      pop  = 1'b1;
      push = beat_valid;
    end else if (beat_valid) begin
      act  = ACT_BYPASS;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_word <= '0;
      w_en      <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
    end else begin
      case (act)
        ACT_BYPASS: begin
          data_word <= masked;
          w_en      <= 1'b1;
        end
        ACT_DRAIN: begin
          data_word <= q_mem[rd_ptr];
          w_en      <= 1'b1;
        end
        default: w_en <= 1'b0;
      endcase

      if (push) begin
        q_mem[wr_ptr] <= masked;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_stream_f.sv
// Directed and random checks of axi_stream_f against a list-based reference model.
module tb_axi_stream_f;
  localparam int unsigned TW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [TW-1:0] info_bits;
  logic [31:0]   dsp_in_data;
  logic          full;
  logic [31:0]   data_word;
  logic          w_en;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_drops  = 0;

  logic [31:0] mq[$];
  logic        exp_wen;
  logic [31:0] exp_dw;

  axi_stream_f #(
    .t_data_w (TW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .info_bits   (info_bits),
    .dsp_in_data (dsp_in_data),
    .full        (full),
    .data_word   (data_word),
    .w_en        (w_en)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mask(input logic [TW-1:0] keep, input logic [31:0] d);
    logic [31:0] m = '0;
    for (int b = 0; b < TW; b++)
      if (keep[b]) m = m | (d & (32'hFF << (8 * b)));
    return m;
  endfunction

  // Pending words form one ordered list; a write takes its head, anything past two is lost.
  task automatic step(input logic [TW-1:0] ib, input logic [31:0] d, input logic f, input string tag);
    logic [31:0] lst[$];
    info_bits   = ib;
    dsp_in_data = d;
    full        = f;
    @(posedge aclk);
    lst = mq;
    if (ib != '0) lst.push_back(ref_mask(ib, d));
    if (!f && lst.size() > 0) begin
      exp_wen = 1'b1;
      exp_dw  = lst.pop_front();
    end else begin
      exp_wen = 1'b0;
    end
    if (lst.size() > 2) begin
      void'(lst.pop_back());
      n_drops++;
    end
    mq = lst;
    #1;
    check({tag, ".w_en"}, 32'(w_en), 32'(exp_wen));
    check({tag, ".data"}, data_word, exp_dw);
  endtask

  initial begin
    aresetn     = 1'b0;
    info_bits   = '0;
    dsp_in_data = '0;
    full        = 1'b0;
    exp_wen     = 1'b0;
    exp_dw      = '0;

    // Reset held 20 ns, sampled across it
    #3;  check("rst.w_en", 32'(w_en), 32'd0); check("rst.data", data_word, 32'd0);
    #14; check("rst2.w_en", 32'(w_en), 32'd0); check("rst2.data", data_word, 32'd0);
    #3;  aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h1234_5678, 1'b0, "idle");

    step(4'b1111, 32'hAABB_CCDD, 1'b0, "bypass");
    check("bypass.const", data_word, 32'hAABB_CCDD);

    step(4'b1111, 32'hAABB_CCDD, 1'b1, "stall0");
    step(4'b1111, 32'hAABB_CCDD, 1'b1, "stall1");
    step(4'b1111, 32'h0102_0304, 1'b0, "drain0");
    check("drain0.const", data_word, 32'hAABB_CCDD);
    step(4'b1111, 32'h0506_0708, 1'b0, "drain1");
    check("drain1.const", data_word, 32'hAABB_CCDD);
    step(4'b0000, 32'h0, 1'b0, "drain2");
    check("drain2.const", data_word, 32'h0102_0304);
    step(4'b0000, 32'h0, 1'b0, "drain3");
    check("drain3.const", data_word, 32'h0506_0708);
    step(4'b0000, 32'h0, 1'b0, "drained");

    step(4'b0011, 32'h1122_3344, 1'b0, "partial");
    check("partial.const", data_word, 32'h0000_3344);
    step(4'b0000, 32'hDEAD_BEEF, 1'b0, "nokeep");
    check("nokeep.const", 32'(w_en), 32'd0);
    step(4'b1111, 32'h0000_0000, 1'b0, "zero");
    check("zero.wen", 32'(w_en), 32'd1);

    // Third beat during a stall is lost; the first two drain in order.
    step(4'b1111, 32'h1111_1111, 1'b1, "ovf0");
    step(4'b0101, 32'h2222_2222, 1'b1, "ovf1");
    step(4'b1111, 32'h3333_3333, 1'b1, "ovf2");
    step(4'b0000, 32'h0, 1'b0, "ovf3");
    check("ovf3.const", data_word, 32'h1111_1111);
    step(4'b0000, 32'h0, 1'b0, "ovf4");
    check("ovf4.const", data_word, 32'h0022_0022);
    step(4'b0000, 32'h0, 1'b0, "ovf5");

    // Asynchronous reset while a write is on the output and a word is queued
    step(4'b1111, 32'h4444_4444, 1'b1, "pre0");
    step(4'b1111, 32'h5555_5555, 1'b0, "pre1");
    #2 aresetn = 1'b0;
    #1;
    check("arst.w_en", 32'(w_en), 32'd0);
    check("arst.data", data_word, 32'd0);
    mq.delete();
    exp_wen = 1'b0;
    exp_dw  = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    step(4'b0000, 32'h0, 1'b0, "postrst");

    for (int i = 0; i < 300; i++) begin
      logic [TW-1:0] ib;
      logic          f;
      ib = ($urandom_range(0, 4) == 0) ? '0 : TW'($urandom);
      f  = ($urandom_range(0, 9) < 4);
      step(ib, $urandom, f, "rand");
      if (f) check("rand.nowr_full", 32'(w_en), 32'd0);
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b0, "flush");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
